// File: rtl/useq_sequencer_pkg.sv
// Shared types and constants for the RVS9 microsequencer: microstate encoding,
// opcode classes and wait-state helper.
package mypack;

   localparam int unsigned OPC_W  = 7;
   localparam int unsigned WCNT_W = 8;

   typedef enum logic [4:0] {
      f0   = 5'd0,
      f1   = 5'd1,
      f2   = 5'd2,
      a0   = 5'd3,
      a1   = 5'd4,
      a2   = 5'd5,
      ai0  = 5'd6,
      ai1  = 5'd7,
      ai2  = 5'd8,
      jr0  = 5'd9,
      lw0  = 5'd10,
      lw1  = 5'd11,
      lw2  = 5'd12,
      lw3  = 5'd13,
      sw0  = 5'd14,
      sw1  = 5'd15,
      sw2  = 5'd16,
      sw3  = 5'd17,
      br0  = 5'd18,
      br1  = 5'd19,
      lui0 = 5'd20,
      jal0 = 5'd21,
      jal1 = 5'd22,
      ill0 = 5'd23
   } uState;

   localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BR    = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;

   // States that wait on the memory handshake.
   function automatic logic is_wait(input uState s);
      return (s == f1) || (s == lw2) || (s == sw2);
   endfunction

endpackage

// File: rtl/useq_sequencer_dispatch.sv
// Opcode-to-entry-state decode used in the f2 dispatch cycle.
module useq_dispatch
   import mypack::*;
(
   input  logic [OPC_W-1:0] opcode,
   output uState            entry,
   output logic             legal
);

   always_comb begin
      entry = f0;
      legal = 1'b1;
      case (opcode)
         OPC_R:     entry = a0;
         OPC_I:     entry = ai0;
         OPC_JALR:  entry = jr0;
         OPC_LOAD:  entry = lw0;
         OPC_STORE: entry = sw0;
         OPC_BR:    entry = br0;
         OPC_LUI:   entry = lui0;
         OPC_JAL:   entry = jal0;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/useq_sequencer.sv
// RVS9 microsequencer: fetch/dispatch/execute uPC stepping with memory wait
// timeout and retired counter. USEQ_ILLEGAL_TRAP_EN enables the sticky ill0 trap.
module useq_sequencer
   import mypack::*;
#(
   parameter int unsigned WAIT_MAX = 16,
   parameter int unsigned RET_W    = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [OPC_W-1:0] opcode,
   input  logic             mem_rdy,
   output uState            uPC,
   output logic             mem_req,
   output logic             instr_done,
   output logic [RET_W-1:0] retired,
   output logic             bus_err,
   output logic             illegal
);

   uState             state_q, state_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   logic [RET_W-1:0]  ret_q, ret_d;
   logic              done_q, done_d;
   logic              berr_q, berr_d;
   uState             disp_entry;
   logic              disp_legal;
   logic              timeout;
   logic              wait_fwd;

   useq_dispatch u_dispatch (
      .opcode (opcode),
      .entry  (disp_entry),
      .legal  (disp_legal)
   );

   assign timeout = (cnt_q == WCNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= f0;
         cnt_q   <= '0;
         ret_q   <= '0;
         done_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
         done_q  <= done_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ret_d    = ret_q;
      done_d   = 1'b0;
      berr_d   = 1'b0;
      wait_fwd = 1'b0;
      if (en) begin
         case (state_q)
            f0:   state_d = f1;
            f2: begin
               if (disp_legal) begin
                  state_d = disp_entry;
               end else begin
`ifdef USEQ_ILLEGAL_TRAP_EN
                  state_d = ill0;
`else
                  state_d = f0;
`endif
               end
            end
            a0:   state_d = a1;
            a1:   state_d = a2;
            ai0:  state_d = ai1;
            ai1:  state_d = ai2;
            lw0:  state_d = lw1;
            lw1:  state_d = lw2;
            sw0:  state_d = sw1;
            sw1:  state_d = sw2;
            br0:  state_d = br1;
            jal0: state_d = jal1;
            f1, lw2, sw2: begin
               // mem_rdy takes priority over the timeout in the same cycle.
               if (mem_rdy) begin
                  wait_fwd = 1'b1;
               end else if (timeout) begin
                  state_d = f0;
                  berr_d  = 1'b1;
               end
               if (wait_fwd) begin
                  case (state_q)
                     f1:      state_d = f2;
                     lw2:     state_d = lw3;
                     default: state_d = sw3;
                  endcase
               end
            end
            a2, ai2, jr0, lw3, sw3, br1, lui0, jal1: begin
               state_d = f0;
               done_d  = 1'b1;
            end
`ifdef USEQ_ILLEGAL_TRAP_EN
            ill0: state_d = ill0;
`endif
            default: state_d = f0;
         endcase

         // Counter restarts on every state change, so entry into a wait state sees 0.
         if (is_wait(state_q) && (state_d == state_q)) begin
            cnt_d = cnt_q + WCNT_W'(1);
         end else begin
            cnt_d = '0;
         end

         if (done_d) begin
            ret_d = ret_q + RET_W'(1);
         end
      end
   end

`ifdef USEQ_ILLEGAL_TRAP_EN
   logic ill_q, ill_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_q <= 1'b0;
      end else begin
         ill_q <= ill_d;
      end
   end

   always_comb begin
      ill_d = ill_q;
      if (en) begin
         ill_d = (state_d == ill0);
      end
   end

   assign illegal = ill_q;
`else
   assign illegal = 1'b0;
`endif

   assign uPC        = state_q;
   assign mem_req    = is_wait(state_q);
   assign instr_done = done_q;
   assign retired    = ret_q;
   assign bus_err    = berr_q;

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed self-checking bench for useq_sequencer (WAIT_MAX=4, RET_W=3 for wrap).
module tb_useq_sequencer;
   import mypack::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [6:0] opcode;
   logic       mem_rdy;
   uState      upc;
   logic       mem_req;
   logic       instr_done;
   logic [2:0] retired;
   logic       bus_err;
   logic       illegal;

   int         checks   = 0;
   int         failures = 0;
   logic [2:0] exp_ret;

   useq_sequencer #(.WAIT_MAX(4), .RET_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .opcode     (opcode),
      .mem_rdy    (mem_rdy),
      .uPC        (upc),
      .mem_req    (mem_req),
      .instr_done (instr_done),
      .retired    (retired),
      .bus_err    (bus_err),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic step_to(input string tag, input uState s);
      tick();
      check(tag, 32'(upc), 32'(s));
   endtask

   task automatic expect_done(input string tag);
      exp_ret = exp_ret + 3'd1;
      check({tag, "_done"}, 32'(instr_done), 32'd1);
      check({tag, "_ret"}, 32'(retired), 32'(exp_ret));
   endtask

   // Zero-wait instruction from f0 back to f0 through n body states.
   task automatic run_instr(input string tag, input logic [6:0] opc, input int n,
                            input uState e0, input uState e1, input uState e2);
      opcode  = opc;
      mem_rdy = 1'b1;
      step_to({tag, "_f1"}, f1);
      check({tag, "_berr_lo"}, 32'(bus_err), 32'd0);
      step_to({tag, "_f2"}, f2);
      step_to({tag, "_b0"}, e0);
      if (n > 1) step_to({tag, "_b1"}, e1);
      if (n > 2) step_to({tag, "_b2"}, e2);
      step_to({tag, "_end"}, f0);
      expect_done(tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      opcode  = OPC_R;
      mem_rdy = 1'b1;
      exp_ret = 3'd0;
      #12;
      check("rst_upc", 32'(upc), 32'(f0));
      check("rst_ret", 32'(retired), 32'd0);
      check("rst_done", 32'(instr_done), 32'd0);
      check("rst_berr", 32'(bus_err), 32'd0);
      check("rst_ill", 32'(illegal), 32'd0);
      check("rst_mreq", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ALU: f0 f1 f2 a0 a1 a2 f0
      step_to("alu_f1", f1);
      check("alu_mreq_f1", 32'(mem_req), 32'd1);
      check("alu_done_lo", 32'(instr_done), 32'd0);
      step_to("alu_f2", f2);
      step_to("alu_a0", a0);
      check("alu_mreq_a0", 32'(mem_req), 32'd0);
      step_to("alu_a1", a1);
      step_to("alu_a2", a2);
      step_to("alu_f0", f0);
      expect_done("alu");

      // Load: mem_rdy low for 3 lw2 cycles, rises in the timeout cycle.
      opcode = OPC_LOAD;
      step_to("ld_f1", f1);
      check("ld_done_clr", 32'(instr_done), 32'd0);
      step_to("ld_f2", f2);
      step_to("ld_lw0", lw0);
      step_to("ld_lw1", lw1);
      mem_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step_to("ld_lw2", lw2);
         check("ld_mreq", 32'(mem_req), 32'd1);
      end
      mem_rdy = 1'b1;
      step_to("ld_lw3", lw3);
      check("ld_berr", 32'(bus_err), 32'd0);
      step_to("ld_f0", f0);
      expect_done("ld");

      // Store: mem_rdy never arrives, timeout after 4 sw2 cycles.
      opcode = OPC_STORE;
      step_to("st_f1", f1);
      step_to("st_f2", f2);
      step_to("st_sw0", sw0);
      mem_rdy = 1'b0;
      step_to("st_sw1", sw1);
      for (int i = 0; i < 4; i++) step_to("st_sw2", sw2);
      step_to("st_f0", f0);
      check("st_berr", 32'(bus_err), 32'd1);
      check("st_done", 32'(instr_done), 32'd0);
      check("st_ret", 32'(retired), 32'(exp_ret));

      run_instr("alui", OPC_I, 3, ai0, ai1, ai2);
      run_instr("jalr", OPC_JALR, 1, jr0, f0, f0);
      run_instr("br", OPC_BR, 2, br0, br1, f0);
      run_instr("lui", OPC_LUI, 1, lui0, f0, f0);
      run_instr("jalr2", OPC_JALR, 1, jr0, f0, f0);
      run_instr("wrap", OPC_JALR, 1, jr0, f0, f0);
      check("wrap_zero", 32'(retired), 32'd0);
      run_instr("jalr3", OPC_JALR, 1, jr0, f0, f0);

      // Undefined opcode.
      opcode = 7'h7F;
      step_to("ill_f1", f1);
      step_to("ill_f2", f2);
`ifdef USEQ_ILLEGAL_TRAP_EN
      step_to("ill_enter", ill0);
      check("ill_flag", 32'(illegal), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step_to("ill_stick", ill0);
         check("ill_flag_hold", 32'(illegal), 32'd1);
      end
      check("ill_ret", 32'(retired), 32'(exp_ret));
      check("ill_done", 32'(instr_done), 32'd0);
      rst_n = 1'b0;
      #2;
      check("ill_rst_upc", 32'(upc), 32'(f0));
      check("ill_rst_flag", 32'(illegal), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_ret = 3'd0;
      run_instr("post_ill", OPC_JALR, 1, jr0, f0, f0);
`else
      step_to("ill_nop", f0);
      check("ill_flag", 32'(illegal), 32'd0);
      check("ill_done", 32'(instr_done), 32'd0);
      check("ill_ret", 32'(retired), 32'(exp_ret));
`endif

      // JAL with en low in jal0, then async reset in jal1.
      opcode  = OPC_JAL;
      mem_rdy = 1'b1;
      step_to("jal_f1", f1);
      step_to("jal_f2", f2);
      step_to("jal_jal0", jal0);
      en      = 1'b0;
      mem_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step_to("jal_frozen", jal0);
         check("jal_frozen_done", 32'(instr_done), 32'd0);
      end
      check("jal_frozen_ret", 32'(retired), 32'(exp_ret));
      en = 1'b1;
      step_to("jal_jal1", jal1);
      #2 rst_n = 1'b0;
      #1;
      check("jal_rst_upc", 32'(upc), 32'(f0));
      check("jal_rst_ret", 32'(retired), 32'd0);
      check("jal_rst_done", 32'(instr_done), 32'd0);
      check("jal_rst_berr", 32'(bus_err), 32'd0);
      tick();
      check("jal_rst_hold", 32'(upc), 32'(f0));
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
